// File: rtl/s298_tb_pkg.sv
// rtl/s298_tb_pkg.sv - shared constants and FSM state type for the s298 response compactor
package s298_tb_pkg;

    localparam int RESP_G66  = 0;
    localparam int RESP_G67  = 1;
    localparam int RESP_G117 = 2;
    localparam int RESP_G118 = 3;
    localparam int RESP_G132 = 4;
    localparam int RESP_G133 = 5;
    localparam int RESP_W    = 6;

    localparam logic [15:0] DEF_POLY = 16'h002D;
    localparam logic [15:0] DEF_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/misr_core.sv
// rtl/misr_core.sv - Galois-form multiple-input signature register
module misr_core #(
    parameter int              SIG_W = 16,
    parameter int              DIN_W = 6,
    parameter logic [SIG_W-1:0] POLY = 16'h002D
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             load,
    input  logic [SIG_W-1:0] seed,
    input  logic             en,
    input  logic [DIN_W-1:0] din,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] sig_next
);

    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0}
                 ^ (sig[SIG_W-1] ? POLY : '0)
                 ^ {{(SIG_W-DIN_W){1'b0}}, din};
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            sig <= '0;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/s298_resp_misr.sv
// rtl/s298_resp_misr.sv - windowed MISR compaction of s298 outputs with golden compare
module s298_resp_misr
    import s298_tb_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter int               WIN_W = 16,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic [5:0]       resp,
    input  logic [SIG_W-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] sig,
    output logic             mismatch,
    input  logic             ack
);

    state_t           state, state_n;
    logic [WIN_W-1:0] cnt, cnt_n;
    logic [SIG_W-1:0] gold_q, gold_n;
    logic [SIG_W-1:0] sig_next;
    logic             mis_n;
    logic             load, en;

    misr_core #(
        .SIG_W (SIG_W),
        .DIN_W (RESP_W),
        .POLY  (POLY)
    ) u_misr (
        .CK       (CK),
        .RST      (RST),
        .load     (load),
        .seed     (SEED),
        .en       (en),
        .din      (resp),
        .sig      (sig),
        .sig_next (sig_next)
    );

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            gold_q   <= '0;
            mismatch <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            gold_q   <= gold_n;
            mismatch <= mis_n;
            busy     <= (state_n == RUN);
            done     <= (state_n == DONE);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gold_n  = gold_q;
        mis_n   = mismatch;
        load    = 1'b0;
        en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load   = 1'b1;
                    gold_n = golden;
                    if (win_len != '0) begin
                        state_n = RUN;
                        cnt_n   = win_len;
                    end else begin
                        state_n = DONE;
                        mis_n   = (SEED != golden);
                    end
                end
            end
            RUN: begin
                en    = 1'b1;
                cnt_n = cnt - WIN_W'(1);
                // The cnt==1 cycle is the last absorb, so compare against the value being written.
                if (cnt == WIN_W'(1)) begin
                    state_n = DONE;
                    mis_n   = (sig_next != gold_q);
                end
            end
            DONE: begin
                if (ack) begin
                    state_n = IDLE;
                    mis_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
